csr_regfile: RTL and testbench

- Machine/supervisor CSR storage for the RV32 core; the responder end of the serialized CSR write stream the CLINT trap sequencer emits (one CSR write per cycle).
- Also serves the WB-stage Zicsr instruction port: combinational read, registered write.
- Drives the live CSR values, the current privilege level and the timer-pending bit back to the CLINT and the pipeline.
- Owns the 64-bit mcycle/minstret counters.

---
 rtl/csr_pkg.sv | 61 ++++++
 rtl/csr_counter64.sv | 30 +++
 rtl/csr_regfile.sv | 204 ++++++++++++++++++++
 tb/tb_csr_regfile.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared CSR definitions: addresses, writable masks, privilege encodings
// and the write-legality decoder used by the register file.
package csr_pkg;

    localparam logic [11:0] CSR_SSTATUS   = 12'h100;
    localparam logic [11:0] CSR_SIE       = 12'h104;
    localparam logic [11:0] CSR_STVEC     = 12'h105;
    localparam logic [11:0] CSR_SSCRATCH  = 12'h140;
    localparam logic [11:0] CSR_SEPC      = 12'h141;
    localparam logic [11:0] CSR_SCAUSE    = 12'h142;
    localparam logic [11:0] CSR_STVAL     = 12'h143;
    localparam logic [11:0] CSR_SIP       = 12'h144;
    localparam logic [11:0] CSR_SATP      = 12'h180;
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MEDELEG   = 12'h302;
    localparam logic [11:0] CSR_MIDELEG   = 12'h303;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [31:0] SSTATUS_MASK = 32'h000C_0122;
    localparam logic [31:0] MEDELEG_MASK = 32'h0000_B3FF;
    localparam logic [31:0] MIDELEG_MASK = 32'h0000_0222;
    localparam logic [31:0] MIP_WMASK    = 32'h0000_0022;
    localparam logic [31:0] MIP_MTIP     = 32'h0000_0080;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    function automatic logic csr_writable(input logic [11:0] addr);
        logic ok;
        case (addr)
            CSR_SSTATUS, CSR_SIE, CSR_STVEC, CSR_SSCRATCH, CSR_SEPC,
            CSR_SCAUSE, CSR_STVAL, CSR_SIP, CSR_SATP,
            CSR_MSTATUS, CSR_MEDELEG, CSR_MIDELEG, CSR_MIE, CSR_MTVEC,
            CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MIP,
            CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter with per-half load; a load suppresses the increment
// for that cycle and leaves the other half untouched.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_i,
    input  logic        ld_lo_i,
    input  logic        ld_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] count_o
);

    logic [63:0] count_r;

    // Counter state: load has priority over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 64'h0;
        end else if (ld_lo_i) begin
            count_r[31:0] <= wdata_i;
        end else if (ld_hi_i) begin
            count_r[63:32] <= wdata_i;
        end else if (inc_i) begin
            count_r <= count_r + 64'd1;
        end
    end

    assign count_o = count_r;

endmodule

// File: rtl/csr_regfile.sv
// Machine/supervisor CSR storage with a CLINT trap write port, a WB-stage
// Zicsr port, privilege tracking and the mcycle/minstret counters.
module csr_regfile
    import csr_pkg::*;
#(
    parameter logic [31:0] MHARTID    = 32'h0000_0000,
    parameter logic [31:0] MISA       = 32'h4014_1105,
    parameter logic [1:0]  RESET_PRIV = 2'b11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trap_we_i,
    input  logic [11:0] trap_waddr_i,
    input  logic [31:0] trap_wdata_i,
    input  logic [11:0] inst_raddr_i,
    output logic [31:0] inst_rdata_o,
    output logic        inst_illegal_o,
    input  logic        inst_we_i,
    input  logic [11:0] inst_waddr_i,
    input  logic [31:0] inst_wdata_i,
    output logic        inst_wr_illegal_o,
    input  logic        priv_we_i,
    input  logic [1:0]  priv_i,
    input  logic        mtip_i,
    input  logic        instret_i,
    output logic [31:0] csr_mstatus_o,
    output logic [31:0] csr_sstatus_o,
    output logic [31:0] csr_mtvec_o,
    output logic [31:0] csr_mepc_o,
    output logic [31:0] csr_mcause_o,
    output logic [31:0] csr_mtval_o,
    output logic [31:0] csr_mie_o,
    output logic [31:0] csr_mip_o,
    output logic [31:0] csr_medeleg_o,
    output logic [31:0] csr_mideleg_o,
    output logic [31:0] csr_stvec_o,
    output logic [31:0] csr_sepc_o,
    output logic [31:0] csr_scause_o,
    output logic [31:0] csr_stval_o,
    output logic [31:0] csr_sie_o,
    output logic [31:0] csr_sip_o,
    output logic [31:0] csr_satp_o,
    output logic [1:0]  csr_privilege_o
);

    logic [31:0] mstatus_r, medeleg_r, mideleg_r, mie_r, mtvec_r, mscratch_r;
    logic [31:0] mepc_r, mcause_r, mtval_r, mip_r;
    logic [31:0] stvec_r, sscratch_r, sepc_r, scause_r, stval_r, satp_r;
    logic [1:0]  priv_r;
    logic [63:0] mcycle_s, minstret_s;
    logic        wr_en_s;
    logic [11:0] wr_addr_s;
    logic [31:0] wr_data_s, mip_s, rdata_s;
    logic        rd_illegal_s;

    // Write arbitration: a trap-port strobe drops the instruction write outright.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = trap_waddr_i;
        wr_data_s = trap_wdata_i;
        if (trap_we_i) begin
            wr_en_s = csr_writable(trap_waddr_i);
        end else if (inst_we_i) begin
            wr_en_s   = csr_writable(inst_waddr_i);
            wr_addr_s = inst_waddr_i;
            wr_data_s = inst_wdata_i;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    assign inst_wr_illegal_o = inst_we_i & ~csr_writable(inst_waddr_i);

    // CSR storage; supervisor views write through into the machine registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_r  <= 32'h0;  medeleg_r  <= 32'h0;  mideleg_r <= 32'h0;
            mie_r      <= 32'h0;  mtvec_r    <= 32'h0;  mscratch_r <= 32'h0;
            mepc_r     <= 32'h0;  mcause_r   <= 32'h0;  mtval_r   <= 32'h0;
            mip_r      <= 32'h0;  stvec_r    <= 32'h0;  sscratch_r <= 32'h0;
            sepc_r     <= 32'h0;  scause_r   <= 32'h0;  stval_r   <= 32'h0;
            satp_r     <= 32'h0;
        end else if (wr_en_s) begin
            case (wr_addr_s)
                CSR_MSTATUS:  mstatus_r  <= wr_data_s;
                CSR_SSTATUS:  mstatus_r  <= (mstatus_r & ~SSTATUS_MASK) | (wr_data_s & SSTATUS_MASK);
                CSR_MEDELEG:  medeleg_r  <= wr_data_s & MEDELEG_MASK;
                CSR_MIDELEG:  mideleg_r  <= wr_data_s & MIDELEG_MASK;
                CSR_MIE:      mie_r      <= wr_data_s;
                CSR_SIE:      mie_r      <= (mie_r & ~mideleg_r) | (wr_data_s & mideleg_r);
                CSR_MIP:      mip_r      <= wr_data_s & MIP_WMASK;
                CSR_SIP:      mip_r      <= (mip_r & ~(mideleg_r & MIP_WMASK)) |
                                            (wr_data_s & mideleg_r & MIP_WMASK);
                CSR_MTVEC:    mtvec_r    <= wr_data_s & 32'hFFFF_FFFD;
                CSR_STVEC:    stvec_r    <= wr_data_s & 32'hFFFF_FFFD;
                CSR_MEPC:     mepc_r     <= wr_data_s & 32'hFFFF_FFFE;
                CSR_SEPC:     sepc_r     <= wr_data_s & 32'hFFFF_FFFE;
                CSR_MSCRATCH: mscratch_r <= wr_data_s;
                CSR_SSCRATCH: sscratch_r <= wr_data_s;
                CSR_MCAUSE:   mcause_r   <= wr_data_s;
                CSR_SCAUSE:   scause_r   <= wr_data_s;
                CSR_MTVAL:    mtval_r    <= wr_data_s;
                CSR_STVAL:    stval_r    <= wr_data_s;
                CSR_SATP:     satp_r     <= wr_data_s;
                default: begin
                end
            endcase
        end
    end

    // Privilege level; the reserved encoding is taken as machine mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            priv_r <= RESET_PRIV;
        end else if (priv_we_i) begin
            priv_r <= (priv_i == 2'b10) ? PRIV_M : priv_i;
        end
    end

    csr_counter64 u_mcycle (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (1'b1),
        .ld_lo_i (wr_en_s && (wr_addr_s == CSR_MCYCLE)),
        .ld_hi_i (wr_en_s && (wr_addr_s == CSR_MCYCLEH)),
        .wdata_i (wr_data_s),
        .count_o (mcycle_s)
    );

    csr_counter64 u_minstret (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (instret_i),
        .ld_lo_i (wr_en_s && (wr_addr_s == CSR_MINSTRET)),
        .ld_hi_i (wr_en_s && (wr_addr_s == CSR_MINSTRETH)),
        .wdata_i (wr_data_s),
        .count_o (minstret_s)
    );

    // MTIP is never stored; it is spliced in from the live timer comparison.
    assign mip_s = (mip_r & MIP_WMASK) | (mtip_i ? MIP_MTIP : 32'h0);

    // Zero-latency read mux for the instruction port.
    always_comb begin
        rdata_s      = 32'h0;
        rd_illegal_s = 1'b0;
        case (inst_raddr_i)
            CSR_MSTATUS:                  rdata_s = mstatus_r;
            CSR_SSTATUS:                  rdata_s = mstatus_r & SSTATUS_MASK;
            CSR_MISA:                     rdata_s = MISA;
            CSR_MEDELEG:                  rdata_s = medeleg_r;
            CSR_MIDELEG:                  rdata_s = mideleg_r;
            CSR_MIE:                      rdata_s = mie_r;
            CSR_SIE:                      rdata_s = mie_r & mideleg_r;
            CSR_MIP:                      rdata_s = mip_s;
            CSR_SIP:                      rdata_s = mip_s & mideleg_r;
            CSR_MTVEC:                    rdata_s = mtvec_r;
            CSR_STVEC:                    rdata_s = stvec_r;
            CSR_MSCRATCH:                 rdata_s = mscratch_r;
            CSR_SSCRATCH:                 rdata_s = sscratch_r;
            CSR_MEPC:                     rdata_s = mepc_r;
            CSR_SEPC:                     rdata_s = sepc_r;
            CSR_MCAUSE:                   rdata_s = mcause_r;
            CSR_SCAUSE:                   rdata_s = scause_r;
            CSR_MTVAL:                    rdata_s = mtval_r;
            CSR_STVAL:                    rdata_s = stval_r;
            CSR_SATP:                     rdata_s = satp_r;
            CSR_MCYCLE, CSR_CYCLE:        rdata_s = mcycle_s[31:0];
            CSR_MCYCLEH, CSR_CYCLEH:      rdata_s = mcycle_s[63:32];
            CSR_MINSTRET, CSR_INSTRET:    rdata_s = minstret_s[31:0];
            CSR_MINSTRETH, CSR_INSTRETH:  rdata_s = minstret_s[63:32];
            CSR_MVENDORID, CSR_MARCHID,
            CSR_MIMPID:                   rdata_s = 32'h0;
            CSR_MHARTID:                  rdata_s = MHARTID;
            default: begin
                rdata_s      = 32'h0;
                rd_illegal_s = 1'b1;
            end
        endcase
    end

    assign inst_rdata_o    = rdata_s;
    assign inst_illegal_o  = rd_illegal_s;

    assign csr_mstatus_o   = mstatus_r;
    assign csr_sstatus_o   = mstatus_r & SSTATUS_MASK;
    assign csr_mtvec_o     = mtvec_r;
    assign csr_mepc_o      = mepc_r;
    assign csr_mcause_o    = mcause_r;
    assign csr_mtval_o     = mtval_r;
    assign csr_mie_o       = mie_r;
    assign csr_mip_o       = mip_s;
    assign csr_medeleg_o   = medeleg_r;
    assign csr_mideleg_o   = mideleg_r;
    assign csr_stvec_o     = stvec_r;
    assign csr_sepc_o      = sepc_r;
    assign csr_scause_o    = scause_r;
    assign csr_stval_o     = stval_r;
    assign csr_sie_o       = mie_r & mideleg_r;
    assign csr_sip_o       = mip_s & mideleg_r;
    assign csr_satp_o      = satp_r;
    assign csr_privilege_o = priv_r;

endmodule

// File: tb/tb_csr_regfile.sv
// Directed bench for csr_regfile: a behavioural CSR model is advanced once per
// clock and compared against every DUT output on each falling edge.
module tb_csr_regfile;

    localparam logic [31:0] HART = 32'h0000_0005;
    localparam logic [31:0] MISA_V = 32'h4014_1105;

    logic clk, rst_n;
    logic trap_we_i, inst_we_i, priv_we_i, mtip_i, instret_i;
    logic [11:0] trap_waddr_i, inst_raddr_i, inst_waddr_i;
    logic [31:0] trap_wdata_i, inst_wdata_i, inst_rdata_o;
    logic inst_illegal_o, inst_wr_illegal_o;
    logic [1:0] priv_i, csr_privilege_o;
    logic [31:0] csr_mstatus_o, csr_sstatus_o, csr_mtvec_o, csr_mepc_o, csr_mcause_o;
    logic [31:0] csr_mtval_o, csr_mie_o, csr_mip_o, csr_medeleg_o, csr_mideleg_o;
    logic [31:0] csr_stvec_o, csr_sepc_o, csr_scause_o, csr_stval_o, csr_sie_o;
    logic [31:0] csr_sip_o, csr_satp_o;

    int n_pass = 0;
    int n_total = 0;
    logic check_en = 1'b0;

    // Model state
    logic [31:0] m_mstatus, m_medeleg, m_mideleg, m_mie, m_mtvec, m_mscratch, m_mepc;
    logic [31:0] m_mcause, m_mtval, m_mip, m_stvec, m_sscratch, m_sepc, m_scause;
    logic [31:0] m_stval, m_satp;
    logic [63:0] m_cycle, m_instret;
    logic [1:0]  m_priv;

    csr_regfile #(.MHARTID(HART)) dut (
        .clk(clk), .rst_n(rst_n),
        .trap_we_i(trap_we_i), .trap_waddr_i(trap_waddr_i), .trap_wdata_i(trap_wdata_i),
        .inst_raddr_i(inst_raddr_i), .inst_rdata_o(inst_rdata_o), .inst_illegal_o(inst_illegal_o),
        .inst_we_i(inst_we_i), .inst_waddr_i(inst_waddr_i), .inst_wdata_i(inst_wdata_i),
        .inst_wr_illegal_o(inst_wr_illegal_o),
        .priv_we_i(priv_we_i), .priv_i(priv_i), .mtip_i(mtip_i), .instret_i(instret_i),
        .csr_mstatus_o(csr_mstatus_o), .csr_sstatus_o(csr_sstatus_o), .csr_mtvec_o(csr_mtvec_o),
        .csr_mepc_o(csr_mepc_o), .csr_mcause_o(csr_mcause_o), .csr_mtval_o(csr_mtval_o),
        .csr_mie_o(csr_mie_o), .csr_mip_o(csr_mip_o), .csr_medeleg_o(csr_medeleg_o),
        .csr_mideleg_o(csr_mideleg_o), .csr_stvec_o(csr_stvec_o), .csr_sepc_o(csr_sepc_o),
        .csr_scause_o(csr_scause_o), .csr_stval_o(csr_stval_o), .csr_sie_o(csr_sie_o),
        .csr_sip_o(csr_sip_o), .csr_satp_o(csr_satp_o), .csr_privilege_o(csr_privilege_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic model_reset();
        m_mstatus = 32'h0; m_medeleg = 32'h0; m_mideleg = 32'h0; m_mie = 32'h0;
        m_mtvec = 32'h0; m_mscratch = 32'h0; m_mepc = 32'h0; m_mcause = 32'h0;
        m_mtval = 32'h0; m_mip = 32'h0; m_stvec = 32'h0; m_sscratch = 32'h0;
        m_sepc = 32'h0; m_scause = 32'h0; m_stval = 32'h0; m_satp = 32'h0;
        m_cycle = 64'h0; m_instret = 64'h0; m_priv = 2'b11;
    endtask

    function automatic logic [31:0] mip_view();
        return m_mip | (mtip_i ? 32'h0000_0080 : 32'h0);
    endfunction

    // Returns {unimplemented, read data} for an address.
    function automatic logic [32:0] mread(input logic [11:0] a);
        logic [31:0] d;
        logic ill;
        ill = 1'b0;
        d = 32'h0;
        case (a)
            12'h300: d = m_mstatus;
            12'h100: d = m_mstatus & 32'h000C_0122;
            12'h301: d = MISA_V;
            12'h302: d = m_medeleg;
            12'h303: d = m_mideleg;
            12'h304: d = m_mie;
            12'h104: d = m_mie & m_mideleg;
            12'h344: d = mip_view();
            12'h144: d = mip_view() & m_mideleg;
            12'h305: d = m_mtvec;
            12'h105: d = m_stvec;
            12'h340: d = m_mscratch;
            12'h140: d = m_sscratch;
            12'h341: d = m_mepc;
            12'h141: d = m_sepc;
            12'h342: d = m_mcause;
            12'h142: d = m_scause;
            12'h343: d = m_mtval;
            12'h143: d = m_stval;
            12'h180: d = m_satp;
            12'hB00, 12'hC00: d = m_cycle[31:0];
            12'hB80, 12'hC80: d = m_cycle[63:32];
            12'hB02, 12'hC02: d = m_instret[31:0];
            12'hB82, 12'hC82: d = m_instret[63:32];
            12'hF11, 12'hF12, 12'hF13: d = 32'h0;
            12'hF14: d = HART;
            default: ill = 1'b1;
        endcase
        return {ill, d};
    endfunction

    function automatic logic writable(input logic [11:0] a);
        logic [32:0] r;
        r = mread(a);
        return !r[32] && (a != 12'h301) && (a[11:8] != 4'hC) && (a[11:4] != 8'hF1);
    endfunction

    task automatic model_write(input logic [11:0] a, input logic [31:0] d);
        case (a)
            12'h300: m_mstatus = d;
            12'h100: m_mstatus = (m_mstatus & ~32'h000C_0122) | (d & 32'h000C_0122);
            12'h302: m_medeleg = d & 32'h0000_B3FF;
            12'h303: m_mideleg = d & 32'h0000_0222;
            12'h304: m_mie = d;
            12'h104: m_mie = (m_mie & ~m_mideleg) | (d & m_mideleg);
            12'h344: m_mip = d & 32'h0000_0022;
            12'h144: m_mip = (m_mip & ~(m_mideleg & 32'h22)) | (d & m_mideleg & 32'h22);
            12'h305: m_mtvec = {d[31:2], 1'b0, d[0]};
            12'h105: m_stvec = {d[31:2], 1'b0, d[0]};
            12'h341: m_mepc = {d[31:1], 1'b0};
            12'h141: m_sepc = {d[31:1], 1'b0};
            12'h340: m_mscratch = d;
            12'h140: m_sscratch = d;
            12'h342: m_mcause = d;
            12'h142: m_scause = d;
            12'h343: m_mtval = d;
            12'h143: m_stval = d;
            12'h180: m_satp = d;
            12'hB00: m_cycle[31:0] = d;
            12'hB80: m_cycle[63:32] = d;
            12'hB02: m_instret[31:0] = d;
            12'hB82: m_instret[63:32] = d;
            default: ;
        endcase
    endtask

    // One clock: the model consumes the inputs present at the edge.
    task automatic cycle();
        logic w;
        logic [11:0] wa;
        logic [31:0] wd;
        @(posedge clk);
        w = 1'b0; wa = 12'h0; wd = 32'h0;
        if (trap_we_i) begin
            if (writable(trap_waddr_i)) begin w = 1'b1; wa = trap_waddr_i; wd = trap_wdata_i; end
        end else if (inst_we_i && writable(inst_waddr_i)) begin
            w = 1'b1; wa = inst_waddr_i; wd = inst_wdata_i;
        end
        if (w) model_write(wa, wd);
        if (!(w && (wa == 12'hB00 || wa == 12'hB80))) m_cycle = m_cycle + 64'd1;
        if (instret_i && !(w && (wa == 12'hB02 || wa == 12'hB82))) m_instret = m_instret + 64'd1;
        if (priv_we_i) m_priv = (priv_i == 2'b10) ? 2'b11 : priv_i;
        #1;
    endtask

    task automatic set_trap(input logic [11:0] a, input logic [31:0] d);
        trap_we_i = 1'b1; trap_waddr_i = a; trap_wdata_i = d;
    endtask

    task automatic set_inst(input logic [11:0] a, input logic [31:0] d);
        inst_we_i = 1'b1; inst_waddr_i = a; inst_wdata_i = d;
    endtask

    task automatic clr();
        trap_we_i = 1'b0; inst_we_i = 1'b0;
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (check_en) begin
            logic [32:0] r;
            r = mread(inst_raddr_i);
            chk("mstatus", csr_mstatus_o, m_mstatus);
            chk("sstatus", csr_sstatus_o, m_mstatus & 32'h000C_0122);
            chk("mtvec", csr_mtvec_o, m_mtvec);
            chk("mepc", csr_mepc_o, m_mepc);
            chk("mcause", csr_mcause_o, m_mcause);
            chk("mtval", csr_mtval_o, m_mtval);
            chk("mie", csr_mie_o, m_mie);
            chk("mip", csr_mip_o, mip_view());
            chk("medeleg", csr_medeleg_o, m_medeleg);
            chk("mideleg", csr_mideleg_o, m_mideleg);
            chk("stvec", csr_stvec_o, m_stvec);
            chk("sepc", csr_sepc_o, m_sepc);
            chk("scause", csr_scause_o, m_scause);
            chk("stval", csr_stval_o, m_stval);
            chk("sie", csr_sie_o, m_mie & m_mideleg);
            chk("sip", csr_sip_o, mip_view() & m_mideleg);
            chk("satp", csr_satp_o, m_satp);
            chk("priv", {30'h0, csr_privilege_o}, {30'h0, m_priv});
            chk("rdata", inst_rdata_o, r[31:0]);
            chk("rd_illegal", {31'h0, inst_illegal_o}, {31'h0, r[32]});
            chk("wr_illegal", {31'h0, inst_wr_illegal_o},
                {31'h0, inst_we_i && !writable(inst_waddr_i)});
        end
    end

    initial begin
        rst_n = 1'b0;
        trap_we_i = 1'b0; trap_waddr_i = 12'h0; trap_wdata_i = 32'h0;
        inst_we_i = 1'b0; inst_waddr_i = 12'h0; inst_wdata_i = 32'h0;
        inst_raddr_i = 12'h0; priv_we_i = 1'b0; priv_i = 2'b00;
        mtip_i = 1'b0; instret_i = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        inst_raddr_i = 12'hF14;
        #1;
        chk("rst_mstatus", csr_mstatus_o, 32'h0);
        chk("rst_priv", {30'h0, csr_privilege_o}, 32'h3);
        chk("hartid", inst_rdata_o, 32'h5);
        chk("hartid_legal", {31'h0, inst_illegal_o}, 32'h0);
        inst_raddr_i = 12'h7C0;
        #1;
        chk("unimp_rdata", inst_rdata_o, 32'h0);
        chk("unimp_illegal", {31'h0, inst_illegal_o}, 32'h1);
        check_en = 1'b1;

        // Trap sequence
        inst_raddr_i = 12'h341;
        set_trap(12'h341, 32'h8000_0105); cycle();
        chk("trap_mepc", csr_mepc_o, 32'h8000_0104);
        set_trap(12'h342, 32'h8000_0007); cycle();
        chk("trap_mcause", csr_mcause_o, 32'h8000_0007);
        set_trap(12'h343, 32'h0); cycle();
        chk("mstatus_pre", csr_mstatus_o, 32'h0);
        set_trap(12'h300, 32'h0000_1880); cycle();
        chk("trap_mstatus", csr_mstatus_o, 32'h0000_1880);

        // Collisions
        set_trap(12'h341, 32'h100); set_inst(12'h341, 32'h200); cycle();
        chk("coll_same", csr_mepc_o, 32'h100);
        set_trap(12'h341, 32'h300); set_inst(12'h340, 32'hABCD); inst_raddr_i = 12'h340; cycle();
        clr();
        chk("coll_mscratch", inst_rdata_o, 32'h0);
        chk("coll_mepc", csr_mepc_o, 32'h300);

        // Views
        set_trap(12'h303, 32'h20); cycle();
        set_trap(12'h300, 32'h0); cycle();
        clr(); set_inst(12'h104, 32'h0000_FFFF); cycle();
        chk("sie_mie", csr_mie_o, 32'h20);
        set_inst(12'h100, 32'hFFFF_FFFF); cycle();
        chk("sstatus_wr", csr_mstatus_o, 32'h000C_0122);
        clr(); mtip_i = 1'b1;
        #1 chk("mtip_live", {31'h0, csr_mip_o[7]}, 32'h1);
        set_trap(12'h344, 32'h0); cycle();
        chk("mip_ro", csr_mip_o, 32'h80);
        clr(); set_inst(12'h144, 32'hFFFF_FFFF); cycle();
        chk("sip_mip", csr_mip_o, 32'hA0);
        chk("sip_view", csr_sip_o, 32'h20);

        // Counter wrap
        set_inst(12'hB80, 32'h0); cycle();
        set_inst(12'hB00, 32'hFFFF_FFFE); cycle();
        clr(); inst_raddr_i = 12'hB00;
        #1 chk("cyc_load", inst_rdata_o, 32'hFFFF_FFFE);
        cycle();
        chk("cyc_ff", inst_rdata_o, 32'hFFFF_FFFF);
        cycle();
        chk("cyc_wrap_lo", inst_rdata_o, 32'h0);
        inst_raddr_i = 12'hC80;
        #1 chk("cyc_wrap_hi", inst_rdata_o, 32'h1);

        // Illegal write and privilege
        set_inst(12'hC00, 32'h5); inst_raddr_i = 12'hB00;
        #1 chk("wr_ill_c00", {31'h0, inst_wr_illegal_o}, 32'h1);
        cycle();
        clr();
        chk("cyc_after_ill", inst_rdata_o, 32'h1);
        priv_we_i = 1'b1; priv_i = 2'b01; cycle();
        chk("priv_s", {30'h0, csr_privilege_o}, 32'h1);
        priv_i = 2'b10; cycle();
        chk("priv_rsvd", {30'h0, csr_privilege_o}, 32'h3);
        priv_i = 2'b00; cycle();
        priv_we_i = 1'b0;

        // minstret and masks
        inst_raddr_i = 12'hC02;
        for (int i = 0; i < 3; i++) begin
            instret_i = 1'b1; cycle();
            instret_i = 1'b0; cycle();
        end
        chk("minstret3", inst_rdata_o, 32'h3);
        set_inst(12'h302, 32'hFFFF_FFFF); cycle();
        chk("medeleg_mask", csr_medeleg_o, 32'h0000_B3FF);
        set_inst(12'h305, 32'hFFFF_FFFF); cycle();
        chk("mtvec_mask", csr_mtvec_o, 32'hFFFF_FFFD);
        set_inst(12'h303, 32'hFFFF_FFFF); cycle();
        chk("mideleg_mask", csr_mideleg_o, 32'h0000_0222);
        set_inst(12'h301, 32'h0); inst_raddr_i = 12'h301; cycle();
        chk("misa_ro", inst_rdata_o, MISA_V);
        set_inst(12'hF14, 32'h7); cycle();
        clr();

        // Reset mid-sequence
        set_trap(12'h341, 32'h44); cycle();
        clr();
        rst_n = 1'b0;
        #1 model_reset();
        chk("rst2_mepc", csr_mepc_o, 32'h0);
        chk("rst2_priv", {30'h0, csr_privilege_o}, 32'h3);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) cycle();

        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
